// File: rtl/layer_dec_pkg.sv
// Shared definitions for the layer frame decoder.
//   CMD_FRAME_WR      command byte that starts (or restarts) a frame write
//   state_t           decoder FSM states
//   DEF_*             default geometry: layers, LEDs per layer, bytes per LED
//   idx_width()       counter width for an index range 0..n-1 (at least 1 bit)
package layer_dec_pkg;

    localparam int DEF_LAYERS      = 8;
    localparam int DEF_LEDS        = 64;
    localparam int DEF_COLOR_BYTES = 3;

    localparam logic [7:0] CMD_FRAME_WR = 8'hCC;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_ptr.sv
// Cascaded write pointer: colour byte -> LED -> layer.
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   clr                return pointer to position 0 (wins over adv)
//   adv                step to the next colour byte position
//   layer_idx          current layer (0..LAYERS-1)
//   led_idx            current LED within layer (0..LEDS-1)
//   col_idx            current colour byte within LED (0..COLOR_BYTES-1)
//   last               pointer sits on the final position of the frame
module layer_ptr
    import layer_dec_pkg::*;
#(
    parameter  int LAYERS      = DEF_LAYERS,
    parameter  int LEDS        = DEF_LEDS,
    parameter  int COLOR_BYTES = DEF_COLOR_BYTES,
    localparam int LW          = idx_width(LAYERS),
    localparam int AW          = idx_width(LEDS),
    localparam int CW          = idx_width(COLOR_BYTES)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          clr,
    input  logic          adv,
    output logic [LW-1:0] layer_idx,
    output logic [AW-1:0] led_idx,
    output logic [CW-1:0] col_idx,
    output logic          last
);

    localparam logic [LW-1:0] LAYER_MAX = LW'(LAYERS - 1);
    localparam logic [AW-1:0] LED_MAX   = AW'(LEDS - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLOR_BYTES - 1);

    logic col_wrap;
    logic led_wrap;
    logic layer_wrap;

    assign col_wrap   = (col_idx == COL_MAX);
    assign led_wrap   = (led_idx == LED_MAX);
    assign layer_wrap = (layer_idx == LAYER_MAX);
    assign last       = col_wrap & led_wrap & layer_wrap;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours; blocking here would let one
    // counter see another's already-updated value within the same edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            layer_idx <= '0;
            led_idx   <= '0;
            col_idx   <= '0;
        end else if (clr) begin
            layer_idx <= '0;
            led_idx   <= '0;
            col_idx   <= '0;
        end else if (adv) begin
            if (col_wrap) begin
                col_idx <= '0;
                if (led_wrap) begin
                    led_idx   <= '0;
                    // Wrapping past the last layer leaves the pointer at 0,
                    // ready for the next frame.
                    layer_idx <= layer_wrap ? '0 : layer_idx + 1'b1;
                end else begin
                    led_idx <= led_idx + 1'b1;
                end
            end else begin
                col_idx <= col_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_dec.sv
// Host byte-stream frame decoder feeding the per-layer WS2812 output stages.
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   dc_in              byte type with byte_rdy_in: 0 = command, 1 = data
//   byte_rdy_in        one-cycle strobe, byte_data_in valid
//   byte_data_in       incoming byte
//   layer_en_out       one-hot target layer, nonzero only in a write cycle
//   wr_addr_out        LED address within the layer (holds between writes)
//   byte_en_out        one-hot colour byte enable, nonzero only in a write cycle
//   byte_data_out      byte to write (holds between writes)
//   frame_rdy_out      one-cycle pulse after the final byte of a frame is written
module layer_dec
    import layer_dec_pkg::*;
#(
    parameter  int LAYERS      = DEF_LAYERS,
    parameter  int LEDS        = DEF_LEDS,
    parameter  int COLOR_BYTES = DEF_COLOR_BYTES,
    localparam int AW          = $clog2(LEDS)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              dc_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic [LAYERS-1:0] layer_en_out,
    output logic [AW-1:0]     wr_addr_out,
    output logic [3:0]        byte_en_out,
    output logic [7:0]        byte_data_out,
    output logic              frame_rdy_out
);

    localparam int LW = idx_width(LAYERS);
    localparam int CW = idx_width(COLOR_BYTES);

    state_t state;
    state_t next_state;

    logic          write_fire;
    logic          ptr_clr;
    logic [LW-1:0] layer_idx;
    logic [AW-1:0] led_idx;
    logic [CW-1:0] col_idx;
    logic          ptr_last;

    logic is_data;
    logic is_frame_cmd;
    logic is_other_cmd;

    assign is_data      = byte_rdy_in & dc_in;
    assign is_frame_cmd = byte_rdy_in & ~dc_in & (byte_data_in == CMD_FRAME_WR);
    assign is_other_cmd = byte_rdy_in & ~dc_in & (byte_data_in != CMD_FRAME_WR);

    layer_ptr #(
        .LAYERS      (LAYERS),
        .LEDS        (LEDS),
        .COLOR_BYTES (COLOR_BYTES)
    ) u_ptr (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .clr       (ptr_clr),
        .adv       (write_fire),
        .layer_idx (layer_idx),
        .led_idx   (led_idx),
        .col_idx   (col_idx),
        .last      (ptr_last)
    );

    // NOTE: every signal driven here gets its default before the case, so
    // no path through the block leaves one unassigned and no latch appears.
    always_comb begin
        next_state = state;
        write_fire = 1'b0;
        ptr_clr    = 1'b0;
        unique case (state)
            // DONE is a single cycle that otherwise behaves like IDLE.
            IDLE, DONE: begin
                next_state = IDLE;
                if (is_frame_cmd) begin
                    ptr_clr    = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (is_data) begin
                    write_fire = 1'b1;
                    if (ptr_last) begin
                        next_state = DONE;
                    end
                end else if (is_frame_cmd) begin
                    ptr_clr = 1'b1;
                end else if (is_other_cmd) begin
                    // Abort: bytes already written stay in the layer RAMs.
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            layer_en_out  <= '0;
            wr_addr_out   <= '0;
            byte_en_out   <= '0;
            byte_data_out <= '0;
            frame_rdy_out <= 1'b0;
        end else begin
            state         <= next_state;
            // Enables pulse for exactly the cycle after the data strobe.
            layer_en_out  <= write_fire ? (LAYERS'(1) << layer_idx) : '0;
            byte_en_out   <= write_fire ? (4'b0001 << col_idx) : 4'b0000;
            if (write_fire) begin
                wr_addr_out   <= led_idx;
                byte_data_out <= byte_data_in;
            end
            // DONE is entered right after the final write is registered, so
            // the pulse lands one cycle after that write cycle.
            frame_rdy_out <= (state == DONE);
        end
    end

endmodule
